// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one full round per clock, ten rounds per block,
// with the round key expanded on the fly alongside the data path.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry k sits at 8*(255-k)+7, i.e. {~k, 3'b111}.
  assign out_o = SBOX_TABLE[{~in_i, 3'b111} -: 8];

endmodule

module aes128_enc_iter #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] cipher_out
);

  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_BUSY = 1'b1
  } mode_e;

  mode_e        mode_q, mode_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [127:0] cipher_q, cipher_d;

  logic [127:0] sub_state;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [127:0] rk_next;
  logic [31:0]  sub_word;
  logic [7:0]   rcon;
  logic         last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    mix_column[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    mix_column[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
  endfunction

  // Byte r of column c moves to column c from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    shift_rows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    mix_columns = '0;
    for (int c = 0; c < 4; c++) begin
      mix_columns[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
  endfunction

  function automatic logic [7:0] rcon_for(input logic [3:0] r);
    case (r)
      4'd1:    rcon_for = 8'h01;
      4'd2:    rcon_for = 8'h02;
      4'd3:    rcon_for = 8'h04;
      4'd4:    rcon_for = 8'h08;
      4'd5:    rcon_for = 8'h10;
      4'd6:    rcon_for = 8'h20;
      4'd7:    rcon_for = 8'h40;
      4'd8:    rcon_for = 8'h80;
      4'd9:    rcon_for = 8'h1b;
      4'd10:   rcon_for = 8'h36;
      default: rcon_for = 8'h00;
    endcase
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sub_byte
    aes_sbox u_sbox (
      .in_i  (state_q[127-8*g -: 8]),
      .out_o (sub_state[127-8*g -: 8])
    );
  end

  // SubWord(RotWord(w3)): w3 rotated left by one byte before substitution.
  for (genvar g = 0; g < 4; g++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_i  (rk_q[(23-8*g+32)%32 -: 8]),
      .out_o (sub_word[31-8*g -: 8])
    );
  end

  assign rcon       = rcon_for(round_q);
  assign last_round = (round_q == 4'd10);

  always_comb begin
    logic [31:0] w4, w5, w6, w7;
    w4      = rk_q[127:96] ^ sub_word ^ {rcon, 24'h0};
    w5      = w4 ^ rk_q[95:64];
    w6      = w5 ^ rk_q[63:32];
    w7      = w6 ^ rk_q[31:0];
    rk_next = {w4, w5, w6, w7};
  end

  assign shifted   = shift_rows(sub_state);
  assign mixed     = mix_columns(shifted);
  assign round_out = (last_round ? shifted : mixed) ^ rk_next;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    mode_d   = mode_q;
    state_d  = state_q;
    rk_d     = rk_q;
    round_d  = round_q;
    done_d   = 1'b0;
    cipher_d = cipher_q;

    case (mode_q)
      MODE_IDLE: begin
        if (start) begin
          state_d = plain_in ^ key_in;
          rk_d    = key_in;
          round_d = 4'd1;
          mode_d  = MODE_BUSY;
        end
      end
      MODE_BUSY: begin
        state_d = round_out;
        rk_d    = rk_next;
        round_d = round_q + 4'd1;
        if (last_round) begin
          cipher_d = round_out;
          done_d   = 1'b1;
          round_d  = 4'd0;
          mode_d   = MODE_IDLE;
          if (ZEROIZE) begin
            state_d = '0;
            rk_d    = '0;
          end
        end
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_IDLE;
      state_q  <= '0;
      rk_q     <= '0;
      round_q  <= '0;
      done_q   <= 1'b0;
      cipher_q <= '0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      rk_q     <= rk_d;
      round_q  <= round_d;
      done_q   <= done_d;
      cipher_q <= cipher_d;
    end
  end

  assign ready      = (mode_q == MODE_IDLE);
  assign done       = done_q;
  assign cipher_out = cipher_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: FIPS-197 vectors, ignored start, back-to-back
// blocks and mid-block reset, scored through an expected-result queue.

module tb_aes128_enc_iter;

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_2 = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] CT3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] RK10_3 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plain_in;
  logic [127:0] key_in;
  logic         ready;
  logic         done;
  logic [127:0] cipher_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  aes128_enc_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plain_in   (plain_in),
    .key_in     (key_in),
    .ready      (ready),
    .done       (done),
    .cipher_out (cipher_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding block.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cipher", cipher_out, e.ct);
        check("latency", 128'(cyc - e.acc), 128'd10);
      end
    end
  end

  // Called at posedge+1; returns at E0+1 with the expected result queued.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
    int waited = 0;
    while (!ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ready) begin
      check("accept_timeout", 128'd0, 128'd1);
    end else begin
      start    = 1'b1;
      plain_in = pt;
      key_in   = key;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back('{ct: ct, acc: cyc});
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    plain_in = '0;
    key_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_cipher", cipher_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 with a start pulse at E3 that must be ignored, ready low through the block.
    accept(PT1, KY1, CT1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("ready_busy", 128'(ready), 128'd0);
      @(posedge clk);
      #1;
      if (i == 2) begin
        start    = 1'b1;
        plain_in = PT2;
        key_in   = KY2;
      end
      if (i == 3) start = 1'b0;
    end
    check("done_after_e10", 128'(done), 128'd1);
    check("ready_done_cycle", 128'(ready), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_extra", 128'(sb.size()), 128'd0);
    check("t1_hold", cipher_out, CT1);

    // T5: T2 accepted in T1's done cycle; round-1 state probe and cipher hold.
    accept(PT1, KY1, CT1);
    begin
      int waited = 0;
      while (!done && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("t5_done_seen", 128'(done), 128'd1);
    end
    accept(PT2, KY2, CT2);
    @(posedge clk);
    #1;
    check("t2_round1_state", dut.state_q, R1_2);
    repeat (4) @(posedge clk);
    #1;
    check("t5_cipher_hold", cipher_out, CT1);
    drain();
    check("t2_hold", cipher_out, CT2);

    // T6: async reset at E5 discards the block; then T3 with round-10 key probe.
    accept(PT1, KY1, CT1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_cipher_zero", cipher_out, 128'd0);
    check("t6_ready", 128'(ready), 128'd1);
    check("t6_done", 128'(done), 128'd0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    accept(128'd0, 128'd0, CT3);
    repeat (9) @(posedge clk);
    #1;
    check("t3_round10", 128'(dut.round_q), 128'd10);
    check("t3_rk10", dut.rk_next, RK10_3);
    drain();
    check("t3_hold", cipher_out, CT3);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
